// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register of the five-stage RISC-V core.
//
// Captures decoded operands and control from ID and presents them to EX. Also
// owns RAW hazard detection (stall_o back to IF/ID), bubble insertion and
// branch flush.
//
// Build option:
//   ID_EX_FORWARD_EN  defined   -> EX operands are resolved from the MEM and
//                                  WB producers; only load-use hazards stall.
//                     undefined -> opA_o/opB_o are the registered read data
//                                  and every EX/MEM RAW hazard stalls.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), async active-high reset
//   valid_i                    ID holds a real instruction
//   pc_i, imm_i                PC and sign-extended immediate
//   rs1addr_i/rs2addr_i/rdaddr_i, use_rs1_i/use_rs2_i  register numbers/use
//   RS1data_i, RS2data_i       register-file read data
//   RegWrite_i..ALUSrc_i, ALUOp_i  decoded control
//   flush_i                    kill the instruction in ID (taken branch)
//   exmem_*_i, memwb_*_i       MEM- and WB-stage producers
//   stall_o                    hold PC and IF/ID this cycle (combinational)
//   valid_o, pc_o, imm_o, *addr_o, control _o   registered copies
//   opA_o, opB_o               EX operands (combinational)
//
// Handshake: valid_i qualifies the ID instruction. stall_o=1 means this
// stage refuses it this cycle: IF/ID must hold the same instruction and a
// bubble (valid_o=0) enters EX. flush_i overrides stall_o and also loads a
// bubble, discarding the ID instruction.
// ---------------------------------------------------------------------------
`ifndef REG_LEN
`define REG_LEN 32
`endif
`ifndef REG_NUM_BITS
`define REG_NUM_BITS 5
`endif

module id_ex_stage (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [`REG_LEN-1:0]      pc_i,
    input  logic [`REG_LEN-1:0]      imm_i,
    input  logic [`REG_NUM_BITS-1:0] rs1addr_i,
    input  logic [`REG_NUM_BITS-1:0] rs2addr_i,
    input  logic [`REG_NUM_BITS-1:0] rdaddr_i,
    input  logic                     use_rs1_i,
    input  logic                     use_rs2_i,
    input  logic [`REG_LEN-1:0]      RS1data_i,
    input  logic [`REG_LEN-1:0]      RS2data_i,
    input  logic                     RegWrite_i,
    input  logic                     MemRead_i,
    input  logic                     MemWrite_i,
    input  logic                     MemtoReg_i,
    input  logic                     ALUSrc_i,
    input  logic [3:0]               ALUOp_i,
    input  logic                     flush_i,
    input  logic [`REG_NUM_BITS-1:0] exmem_rd_i,
    input  logic                     exmem_RegWrite_i,
    input  logic [`REG_LEN-1:0]      exmem_data_i,
    input  logic [`REG_NUM_BITS-1:0] memwb_rd_i,
    input  logic                     memwb_RegWrite_i,
    input  logic [`REG_LEN-1:0]      memwb_data_i,
    output logic                     stall_o,
    output logic                     valid_o,
    output logic [`REG_LEN-1:0]      pc_o,
    output logic [`REG_LEN-1:0]      imm_o,
    output logic [`REG_NUM_BITS-1:0] rs1addr_o,
    output logic [`REG_NUM_BITS-1:0] rs2addr_o,
    output logic [`REG_NUM_BITS-1:0] rdaddr_o,
    output logic                     RegWrite_o,
    output logic                     MemRead_o,
    output logic                     MemWrite_o,
    output logic                     MemtoReg_o,
    output logic                     ALUSrc_o,
    output logic [3:0]               ALUOp_o,
    output logic [`REG_LEN-1:0]      opA_o,
    output logic [`REG_LEN-1:0]      opB_o
);

    // Pipeline register state
    logic                     valid_q,    valid_d;
    logic [`REG_LEN-1:0]      pc_q,       pc_d;
    logic [`REG_LEN-1:0]      imm_q,      imm_d;
    logic [`REG_NUM_BITS-1:0] rs1addr_q,  rs1addr_d;
    logic [`REG_NUM_BITS-1:0] rs2addr_q,  rs2addr_d;
    logic [`REG_NUM_BITS-1:0] rdaddr_q,   rdaddr_d;
    logic                     regwrite_q, regwrite_d;
    logic                     memread_q,  memread_d;
    logic                     memwrite_q, memwrite_d;
    logic                     memtoreg_q, memtoreg_d;
    logic                     alusrc_q,   alusrc_d;
    logic [3:0]               aluop_q,    aluop_d;
    logic [`REG_LEN-1:0]      rs1data_q,  rs1data_d;
    logic [`REG_LEN-1:0]      rs2data_q,  rs2data_d;

    logic ex_hit;
    logic hazard_cond;
    logic stall;

    // ID reads the register written by the instruction currently in EX.
    assign ex_hit = valid_i && regwrite_q && (rdaddr_q != '0) &&
                    ((use_rs1_i && (rs1addr_i == rdaddr_q)) ||
                     (use_rs2_i && (rs2addr_i == rdaddr_q)));

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot be forwarded in time: its data appears in MEM.
    assign hazard_cond = ex_hit && memread_q;

    always_comb begin
        opA_o = rs1data_q;
        if (exmem_RegWrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1addr_q))
            opA_o = exmem_data_i;
        else if (memwb_RegWrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1addr_q))
            opA_o = memwb_data_i;
    end

    always_comb begin
        opB_o = rs2data_q;
        if (exmem_RegWrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2addr_q))
            opB_o = exmem_data_i;
        else if (memwb_RegWrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2addr_q))
            opB_o = memwb_data_i;
    end
`else
    logic mem_hit;
    logic unused_fwd_inputs;

    // Producer in MEM: its result reaches the register file one cycle later,
    // after which the write-through read is correct.
    assign mem_hit = valid_i && exmem_RegWrite_i && (exmem_rd_i != '0) &&
                     ((use_rs1_i && (rs1addr_i == exmem_rd_i)) ||
                      (use_rs2_i && (rs2addr_i == exmem_rd_i)));

    assign hazard_cond = (ex_hit && valid_q) || mem_hit;

    assign opA_o = rs1data_q;
    assign opB_o = rs2data_q;

    assign unused_fwd_inputs = ^{exmem_data_i, memwb_data_i, memwb_rd_i, memwb_RegWrite_i};
`endif

    // Reset forces stall low so IF/ID never sees a stall from stale inputs.
    assign stall   = hazard_cond && !flush_i && !rst_i;
    assign stall_o = stall;

    always_comb begin
        // Bubble by default: everything zero.
        valid_d    = 1'b0;
        pc_d       = '0;
        imm_d      = '0;
        rs1addr_d  = '0;
        rs2addr_d  = '0;
        rdaddr_d   = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        alusrc_d   = 1'b0;
        aluop_d    = '0;
        rs1data_d  = '0;
        rs2data_d  = '0;
        if (!(flush_i || stall)) begin
            valid_d    = valid_i;
            pc_d       = pc_i;
            imm_d      = imm_i;
            rs1addr_d  = rs1addr_i;
            rs2addr_d  = rs2addr_i;
            rdaddr_d   = rdaddr_i;
            regwrite_d = RegWrite_i && valid_i;
            memread_d  = MemRead_i  && valid_i;
            memwrite_d = MemWrite_i && valid_i;
            memtoreg_d = MemtoReg_i && valid_i;
            alusrc_d   = ALUSrc_i   && valid_i;
            aluop_d    = ALUOp_i & {4{valid_i}};
            rs1data_d  = RS1data_i;
            rs2data_d  = RS2data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1addr_q  <= '0;
            rs2addr_q  <= '0;
            rdaddr_q   <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            rs1data_q  <= '0;
            rs2data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1addr_q  <= rs1addr_d;
            rs2addr_q  <= rs2addr_d;
            rdaddr_q   <= rdaddr_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            rs1data_q  <= rs1data_d;
            rs2data_q  <= rs2data_d;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign imm_o      = imm_q;
    assign rs1addr_o  = rs1addr_q;
    assign rs2addr_o  = rs2addr_q;
    assign rdaddr_o   = rdaddr_q;
    assign RegWrite_o = regwrite_q;
    assign MemRead_o  = memread_q;
    assign MemWrite_o = memwrite_q;
    assign MemtoReg_o = memtoreg_q;
    assign ALUSrc_o   = alusrc_q;
    assign ALUOp_o    = aluop_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. The bench owns the downstream pipeline (MEM/WB
// producers follow whatever left EX) and keeps a reference model of the
// instruction held in EX.
module tb_id_ex_stage;

    localparam int W = 89;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    // ---------------- DUT inputs ----------------
    logic        id_valid = 0, id_u1 = 0, id_u2 = 0, id_flush = 0;
    logic [31:0] id_pc = 0, id_imm = 0, id_d1 = 0, id_d2 = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic        id_rw = 0, id_mr = 0, id_mw = 0, id_m2r = 0, id_as = 0;
    logic [3:0]  id_op = 0;
    logic [4:0]  mem_rd = 0, wb_rd = 0;
    logic        mem_rw = 0, wb_rw = 0;
    logic [31:0] mem_data = 0, wb_data = 0;

    // ---------------- DUT outputs ----------------
    logic        stall_o, valid_o;
    logic [31:0] pc_o, imm_o, opA_o, opB_o;
    logic [4:0]  rs1addr_o, rs2addr_o, rdaddr_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o;
    logic [3:0]  ALUOp_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(id_valid),
        .pc_i(id_pc), .imm_i(id_imm),
        .rs1addr_i(id_rs1), .rs2addr_i(id_rs2), .rdaddr_i(id_rd),
        .use_rs1_i(id_u1), .use_rs2_i(id_u2),
        .RS1data_i(id_d1), .RS2data_i(id_d2),
        .RegWrite_i(id_rw), .MemRead_i(id_mr), .MemWrite_i(id_mw),
        .MemtoReg_i(id_m2r), .ALUSrc_i(id_as), .ALUOp_i(id_op),
        .flush_i(id_flush),
        .exmem_rd_i(mem_rd), .exmem_RegWrite_i(mem_rw), .exmem_data_i(mem_data),
        .memwb_rd_i(wb_rd), .memwb_RegWrite_i(wb_rw), .memwb_data_i(wb_data),
        .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o), .imm_o(imm_o),
        .rs1addr_o(rs1addr_o), .rs2addr_o(rs2addr_o), .rdaddr_o(rdaddr_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .opA_o(opA_o), .opB_o(opB_o)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, m2r, as;
        logic [3:0]  op;
        logic [31:0] d1, d2;
    } ex_t;

    ex_t ex_m = '0;
    logic rand_data = 1'b1;
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic id_reads(input logic [4:0] r);
        return (r != 0) && ((id_u1 && id_rs1 == r) || (id_u2 && id_rs2 == r));
    endfunction

    function automatic logic exp_stall();
        if (rst_i || id_flush || !id_valid) return 1'b0;
`ifdef ID_EX_FORWARD_EN
        return ex_m.valid && ex_m.rw && ex_m.mr && id_reads(ex_m.rd);
`else
        return (ex_m.valid && ex_m.rw && id_reads(ex_m.rd)) || (mem_rw && id_reads(mem_rd));
`endif
    endfunction

    function automatic logic [31:0] exp_operand(input logic [4:0] r, input logic [31:0] regv);
`ifdef ID_EX_FORWARD_EN
        if (r != 0 && mem_rw && mem_rd == r) return mem_data;
        if (r != 0 && wb_rw && wb_rd == r) return wb_data;
`endif
        return regv;
    endfunction

    function automatic logic [W-1:0] pack_exp(input ex_t e);
        return {e.valid, e.pc, e.imm, e.rs1, e.rs2, e.rd, e.rw, e.mr, e.mw, e.m2r, e.as, e.op};
    endfunction

    function automatic logic [W-1:0] pack_obs();
        return {valid_o, pc_o, imm_o, rs1addr_o, rs2addr_o, rdaddr_o,
                RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o};
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = r1; id_u1 = u1; id_rs2 = r2; id_u2 = u2; id_rd = rd;
        id_rw = rw; id_mr = mr; id_mw = mw; id_m2r = mr;
        id_as = 1'($urandom_range(0, 1)); id_op = 4'($urandom_range(0, 15));
        id_pc = $urandom; id_imm = $urandom; id_d1 = $urandom; id_d2 = $urandom;
        id_flush = 1'b0;
    endtask

    // One clock cycle: check the combinational outputs, then the capture.
    task automatic step(output logic st);
        logic e_st;
        if (rand_data) begin
            mem_data = $urandom;
            wb_data  = $urandom;
        end
        #1;
        e_st = exp_stall();
        chk("stall", stall_o, e_st);
        chk("opA", opA_o, exp_operand(ex_m.rs1, ex_m.d1));
        chk("opB", opB_o, exp_operand(ex_m.rs2, ex_m.d2));
        st = stall_o;
        @(posedge clk_i);
        #1;
        wb_rd = mem_rd; wb_rw = mem_rw;
        mem_rd = ex_m.rd; mem_rw = ex_m.rw;
        if (id_flush || e_st) begin
            ex_m = '0;
        end else begin
            ex_m.valid = id_valid;
            ex_m.pc = id_pc; ex_m.imm = id_imm;
            ex_m.rs1 = id_rs1; ex_m.rs2 = id_rs2; ex_m.rd = id_rd;
            ex_m.rw = id_rw & id_valid; ex_m.mr = id_mr & id_valid;
            ex_m.mw = id_mw & id_valid; ex_m.m2r = id_m2r & id_valid;
            ex_m.as = id_as & id_valid; ex_m.op = id_op & {4{id_valid}};
            ex_m.d1 = id_d1; ex_m.d2 = id_d2;
        end
        exp_q.push_back(pack_exp(ex_m));
        chk("ex_regs", pack_obs(), exp_q.pop_front());
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic s;
        int n;
        int exp_len;
        logic [31:0] saved;

        // Reset state
        #3;
        chk("rst_regs", pack_obs(), '0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_opA", opA_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Load-use: lw x5 then add x6,x5,x1
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        step(s);
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        saved = id_d1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(s);
            if (!s) break;
            n++;
        end
`ifdef ID_EX_FORWARD_EN
        exp_len = 1;
`else
        exp_len = 2;
`endif
        chk("lu_stall_len", n, exp_len);
        rand_data = 1'b0;
        wb_data = 32'h1234;
        mem_data = $urandom;
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("lu_fwd_opA", opA_o, 32'h1234);
`else
        chk("lu_reg_opA", opA_o, saved);
`endif
        step(s);

        // MEM over WB priority for x7, then rd=0 never forwarded
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0);
        saved = id_d1;
        step(s);
        mem_rd = 5'd7; mem_rw = 1; mem_data = 32'hAAAA;
        wb_rd  = 5'd7; wb_rw  = 1; wb_data  = 32'hBBBB;
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("fwd_mem_prio", opA_o, 32'hAAAA);
`else
        chk("nofwd_opA", opA_o, saved);
`endif
        saved = id_d1;
        step(s);
        mem_rd = 5'd0; mem_rw = 1; mem_data = 32'hAAAA;
        wb_rd  = 5'd0; wb_rw  = 1; wb_data  = 32'hBBBB;
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        #1;
        chk("x0_no_fwd", opA_o, saved);
        step(s);
        rand_data = 1'b1;

        // addi x3 then sub x4,x3,x3
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0);
        step(s);
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
        id_d1 = 32'hC0DE;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(s);
            if (!s) break;
            n++;
        end
`ifdef ID_EX_FORWARD_EN
        exp_len = 0;
`else
        exp_len = 2;
`endif
        chk("raw_stall_len", n, exp_len);
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        #1;
`ifdef ID_EX_FORWARD_EN
        chk("raw_opA", opA_o, mem_data);
`else
        chk("raw_opA", opA_o, 32'hC0DE);
`endif
        step(s);

        // Flush during a load-use hazard
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        step(s);
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1);
        id_flush = 1'b1;
        #1;
        chk("flush_stall", stall_o, 1'b0);
        step(s);
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_rw", RegWrite_o, 1'b0);
        chk("flush_mw", MemWrite_o, 1'b0);
        id_flush = 1'b0;

        // valid_i=0 with RegWrite_i=1
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1);
        step(s);
        chk("inv_rw", RegWrite_o, 1'b0);
        chk("inv_mw", MemWrite_o, 1'b0);
        set_id(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 0);
        #1;
        chk("inv_no_hazard", stall_o, 1'b0);
        step(s);

        // Random traffic; a stalled ID instruction is held as IF/ID would
        s = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!s) begin
                set_id(1'($urandom_range(0, 4) != 0),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            id_flush = ($urandom_range(0, 7) == 0);
            step(s);
        end
        id_flush = 1'b0;

        // Reset asserted mid-run with a valid instruction and a live hazard
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        step(s);
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        mem_rd = 5'd5; mem_rw = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_regs", pack_obs(), '0);
        chk("midrst_stall", stall_o, 1'b0);
        chk("midrst_opA", opA_o, 32'h0);
        chk("midrst_opB", opB_o, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        ex_m = '0;
        mem_rd = 0; mem_rw = 0; wb_rd = 0; wb_rw = 0;
        step(s);
        step(s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule
